full_adder_bist: RTL and testbench
==================================

# full_adder_bist

Built-in self-test controller for the `full_adder` cell. It is the stimulus-and-check side of the adder interface: it drives all eight `a/b/cin` combinations onto a DUT and compares the returned `sum/cout` against golden values. It then reports pass/fail, a saturating mismatch count and the first failing vector. It sits beside each `full_adder` instance and is started by a test/control register block.

## Interface
- `DUT_LATENCY`, 1: cycles from driven inputs to valid DUT outputs. Legal range 0..3; 0 means a combinational DUT.
- `LOOPS`, 1: number of full 8-vector sweeps per run. Legal range 1..255.
- `clk_i`  in  1: single clock. All logic is on the rising edge.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: run request. Sampled only in IDLE or DONE.
- `dut_a_o`  out  1: stimulus `a`. Equals `vec[0]`.
- `dut_b_o`  out  1: stimulus `b`. Equals `vec[1]`.
- `dut_cin_o`  out  1: stimulus `cin`. Equals `vec[2]`.
- `dut_sum_i`  in  1: DUT sum response.
- `dut_cout_i`  in  1: DUT carry response.
- `busy_o`  out  1: run in progress.
- `done_o`  out  1: run complete. Held high until the next accepted start or reset.
- `pass_o`  out  1: `done_o` and zero mismatches.
- `fail_count_o`  out  8: mismatch count. Saturates at 255.
- `first_fail_vld_o`  out  1: at least one mismatch has been recorded this run.
- `first_fail_vec_o`  out  3: `{cin,b,a}` of the earliest mismatch.

## Operation
- **State machine:** IDLE -> DRIVE -> DRAIN -> DONE.
  - IDLE -> DRIVE: on `start_i`=1.
  - DONE -> DRIVE: on `start_i`=1.
  - DRIVE -> DRAIN: after the last vector of the last loop.
  - DRAIN -> DONE: after `DUT_LATENCY` cycles. When `DUT_LATENCY`=0, DRAIN is skipped and DRIVE goes directly to DONE.
- **Clearing on accepted start:** `fail_count_o`, `first_fail_*`, `done_o` and `pass_o` clear; the vector counter and loop counter reset to 0.
- **DRIVE:**
  - The 3-bit vector counter increments once per cycle and wraps 7 -> 0.
  - The loop counter increments on each wrap.
  - Exit from DRIVE occurs when vector = 7 and loop = `LOOPS`-1.
- **Stimulus outputs:** `dut_*_o` are registered. They are 0 in all states other than DRIVE.
- **Golden model:** `sum = a^b^cin`; `cout = (a&b)|((a^b)&cin)`.
- **Check pipeline:** the golden values, the vector and a valid bit are shifted through a `DUT_LATENCY`-deep pipeline.
  - On a valid slot, the block compares against `dut_sum_i`/`dut_cout_i`.
  - A mismatch on either bit counts as one failure.
  - The first mismatch of a run latches `first_fail_vec_o` and sets `first_fail_vld_o`.
- **Start while busy:** `start_i` in DRIVE or DRAIN is ignored and has no side effects.
- **Reset:** asserting `reset_n_i` mid-run aborts the run immediately with no completion report. All counters and the pipeline clear.

## Timing
- **Reset values:** all outputs are 0, including `dut_*_o`, `busy_o`, `done_o`, `pass_o`, `fail_count_o`, `first_fail_vld_o` and `first_fail_vec_o`. State is IDLE.
- **Start acceptance:** `start_i` is sampled high at the edge ending cycle n.
  - Cycle n+1: `busy_o`=1 and `dut_*_o` = vector 0.
  - Vector j (global index j = 0..8*`LOOPS`-1) is driven in cycle n+1+j.
- **Response sampling:** the response for vector j is sampled at the end of cycle n+1+j+`DUT_LATENCY`. With latency 0 this is the same cycle the vector is driven.
- **Completion:**
  - `busy_o` is high for exactly 8*`LOOPS`+`DUT_LATENCY` cycles.
  - In cycle n+1+8*`LOOPS`+`DUT_LATENCY`: `busy_o`=0, `done_o`=1, and `pass_o` is valid.
- **Counter visibility:** `fail_count_o` updates the cycle after the mismatching sample. It is final when `done_o` rises.
- **Restart from DONE:** a start accepted in DONE drops `done_o` in cycle n+1, the same cycle `busy_o` rises.

## Test plan
- **Correct DUT:** correct registered adder, `DUT_LATENCY`=1, `LOOPS`=1, start at cycle 0 -> vectors 0..7 on cycles 1..8; `done_o`=1 at cycle 10; `pass_o`=1; `fail_count_o`=0; `first_fail_vld_o`=0.
- **Sum stuck-at-0:** `dut_sum_i` stuck-at-0 -> `fail_count_o`=4 (vectors 1, 2, 4, 7); `first_fail_vec_o`=3'b001; `pass_o`=0.
- **Inverted carry:** `dut_cout_i` inverted, `LOOPS`=40 -> 320 mismatches saturate, so `fail_count_o`=255; `first_fail_vec_o`=3'b000.
- **Latency sweep:** `DUT_LATENCY`=0 with a combinational model, then `DUT_LATENCY`=3 with a 3-stage model -> both runs pass. Busy lengths are 8 and 11 cycles respectively.
- **Start handling:** pulse `start_i` in DRIVE cycle 4 -> ignored and the run completes normally. Then start again from DONE -> `done_o` drops, counters clear, and a second run passes.
- **Reset mid-run:** assert `reset_n_i`=0 in DRIVE cycle 5 -> all outputs 0 immediately. After release, the block stays IDLE until `start_i`.

Source files
------------

// File: rtl/full_adder_bist.sv
// full_adder_bist: exhaustive 8-vector self-test for a full_adder cell.
// Drives a/b/cin sweeps, checks sum/cout after DUT_LATENCY, reports results.
module full_adder_bist #(
  parameter int DUT_LATENCY = 1,
  parameter int LOOPS       = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  output logic       dut_a_o,
  output logic       dut_b_o,
  output logic       dut_cin_o,
  input  logic       dut_sum_i,
  input  logic       dut_cout_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] fail_count_o,
  output logic       first_fail_vld_o,
  output logic [2:0] first_fail_vec_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);
  localparam logic [1:0] DRAIN_LAST =
    2'((DUT_LATENCY == 0) ? 0 : DUT_LATENCY - 1);
  localparam state_t AFTER_DRIVE =
    (DUT_LATENCY == 0) ? S_DONE : S_DRAIN;

  state_t     state;
  logic [2:0] vec;
  logic [7:0] loop_cnt;
  logic [1:0] drain_cnt;

  logic       accept;
  logic       last_vec;
  logic       cur_vld;
  logic [1:0] cur_gold;
  logic [2:0] nxt_vec;
  logic       chk_vld;
  logic [2:0] chk_vec;
  logic [1:0] chk_gold;
  logic       mism;
  logic       clean_run;

  assign accept   = start_i &&
                    (state == S_IDLE || state == S_DONE);
  assign last_vec = (vec == 3'd7) && (loop_cnt == LOOP_LAST);
  assign nxt_vec  = vec + 3'd1;
  assign cur_vld  = (state == S_DRIVE);
  assign cur_gold = {(vec[0] & vec[1]) | ((vec[0] ^ vec[1]) & vec[2]),
                     ^vec};
  assign busy_o   = (state == S_DRIVE) || (state == S_DRAIN);

  // Check slot: vector, golden pair and valid delayed to meet the response
  if (DUT_LATENCY == 0) begin : g_comb
    assign chk_vld  = cur_vld;
    assign chk_vec  = vec;
    assign chk_gold = cur_gold;
  end else begin : g_pipe
    logic [DUT_LATENCY-1:0] vld_q;
    logic [2:0]             vec_q  [DUT_LATENCY];
    logic [1:0]             gold_q [DUT_LATENCY];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        vld_q <= '0;
        for (int i = 0; i < DUT_LATENCY; i++) begin
          vec_q[i]  <= '0;
          gold_q[i] <= '0;
        end
      end else begin
        vld_q[0]  <= cur_vld;
        vec_q[0]  <= vec;
        gold_q[0] <= cur_gold;
        for (int i = 1; i < DUT_LATENCY; i++) begin
          vld_q[i]  <= vld_q[i-1];
          vec_q[i]  <= vec_q[i-1];
          gold_q[i] <= gold_q[i-1];
        end
      end
    end

    assign chk_vld  = vld_q[DUT_LATENCY-1];
    assign chk_vec  = vec_q[DUT_LATENCY-1];
    assign chk_gold = gold_q[DUT_LATENCY-1];
  end

  assign mism = chk_vld &&
                ({dut_cout_i, dut_sum_i} != chk_gold);
  // The last sample lands on the same edge that enters DONE
  assign clean_run = (fail_count_o == 8'd0) && !mism;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= S_IDLE;
      vec              <= '0;
      loop_cnt         <= '0;
      drain_cnt        <= '0;
      dut_a_o          <= 1'b0;
      dut_b_o          <= 1'b0;
      dut_cin_o        <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      fail_count_o     <= '0;
      first_fail_vld_o <= 1'b0;
      first_fail_vec_o <= '0;
    end else begin
      if (accept) begin
        fail_count_o     <= '0;
        first_fail_vld_o <= 1'b0;
        first_fail_vec_o <= '0;
        done_o           <= 1'b0;
        pass_o           <= 1'b0;
      end else if (mism) begin
        if (fail_count_o != 8'hff)
          fail_count_o <= fail_count_o + 8'd1;
        if (!first_fail_vld_o) begin
          first_fail_vld_o <= 1'b1;
          first_fail_vec_o <= chk_vec;
        end
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_DRIVE;
            vec      <= '0;
            loop_cnt <= '0;
            {dut_cin_o, dut_b_o, dut_a_o} <= 3'b000;
          end
        end
        S_DRIVE: begin
          if (last_vec) begin
            state     <= AFTER_DRIVE;
            drain_cnt <= '0;
            {dut_cin_o, dut_b_o, dut_a_o} <= 3'b000;
            if (DUT_LATENCY == 0) begin
              done_o <= 1'b1;
              pass_o <= clean_run;
            end
          end else begin
            vec <= nxt_vec;
            {dut_cin_o, dut_b_o, dut_a_o} <= nxt_vec;
            if (vec == 3'd7)
              loop_cnt <= loop_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            pass_o <= clean_run;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: four BIST instances (latency/loop variants)
// against reference adder models with injectable output faults.
module tb_full_adder_bist;

  localparam int NI = 4;

  typedef struct {
    logic a;
    logic b;
    logic cin;
  } vec_t;

  typedef struct {
    int fault;
    bit mid_start;
    int fail_small;
    int fail_u1;
    int first;
    bit fvld;
    bit pass;
  } run_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   fault;

  logic       a [NI];
  logic       b [NI];
  logic       cin [NI];
  logic       sum [NI];
  logic       cout [NI];
  logic       busy [NI];
  logic       done [NI];
  logic       pass [NI];
  logic       fvld [NI];
  logic [7:0] fcnt [NI];
  logic [2:0] fvec [NI];

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vt [8];
  run_t rt [5];

  always #5 clk = ~clk;

  full_adder_bist #(.DUT_LATENCY(1), .LOOPS(1)) u0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .dut_a_o(a[0]), .dut_b_o(b[0]), .dut_cin_o(cin[0]),
    .dut_sum_i(sum[0]), .dut_cout_i(cout[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .fail_count_o(fcnt[0]), .first_fail_vld_o(fvld[0]),
    .first_fail_vec_o(fvec[0]));

  full_adder_bist #(.DUT_LATENCY(1), .LOOPS(40)) u1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .dut_a_o(a[1]), .dut_b_o(b[1]), .dut_cin_o(cin[1]),
    .dut_sum_i(sum[1]), .dut_cout_i(cout[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .fail_count_o(fcnt[1]), .first_fail_vld_o(fvld[1]),
    .first_fail_vec_o(fvec[1]));

  full_adder_bist #(.DUT_LATENCY(0), .LOOPS(1)) u2 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .dut_a_o(a[2]), .dut_b_o(b[2]), .dut_cin_o(cin[2]),
    .dut_sum_i(sum[2]), .dut_cout_i(cout[2]),
    .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]),
    .fail_count_o(fcnt[2]), .first_fail_vld_o(fvld[2]),
    .first_fail_vec_o(fvec[2]));

  full_adder_bist #(.DUT_LATENCY(3), .LOOPS(1)) u3 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .dut_a_o(a[3]), .dut_b_o(b[3]), .dut_cin_o(cin[3]),
    .dut_sum_i(sum[3]), .dut_cout_i(cout[3]),
    .busy_o(busy[3]), .done_o(done[3]), .pass_o(pass[3]),
    .fail_count_o(fcnt[3]), .first_fail_vld_o(fvld[3]),
    .first_fail_vec_o(fvec[3]));

  logic [1:0] r0, r1, r3a, r3b, r3c, c2;
  logic [1:0] raw [NI];

  always @(posedge clk) begin
    r0  <= {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, cin[0]};
    r1  <= {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, cin[1]};
    r3a <= {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, cin[3]};
    r3b <= r3a;
    r3c <= r3b;
  end

  assign c2 = {1'b0, a[2]} + {1'b0, b[2]} + {1'b0, cin[2]};
  assign raw[0] = r0;
  assign raw[1] = r1;
  assign raw[2] = c2;
  assign raw[3] = r3c;

  // fault 1: sum stuck-at-0, fault 2: carry inverted
  for (genvar g = 0; g < NI; g++) begin : g_flt
    assign sum[g]  = (fault == 1) ? 1'b0 : raw[g][0];
    assign cout[g] = raw[g][1] ^ (fault == 2);
  end

  function automatic int lat_of(input int i);
    case (i)
      2: return 0;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int loops_of(input int i);
    return (i == 1) ? 40 : 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_stim_u%0d", tag, i),
          {cin[i], b[i], a[i]}, 0);
      chk($sformatf("%s_busy_u%0d", tag, i), busy[i], 0);
      chk($sformatf("%s_done_u%0d", tag, i), done[i], 0);
      chk($sformatf("%s_pass_u%0d", tag, i), pass[i], 0);
      chk($sformatf("%s_fcnt_u%0d", tag, i), fcnt[i], 0);
      chk($sformatf("%s_fvld_u%0d", tag, i), fvld[i], 0);
      chk($sformatf("%s_fvec_u%0d", tag, i), fvec[i], 0);
    end
  endtask

  task automatic run(input int id, input run_t r);
    int dk [NI];
    int bc [NI];
    int k;
    bit all;
    int ef;
    fault = r.fault;
    for (int i = 0; i < NI; i++) begin
      dk[i] = 0;
      bc[i] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k   = 1;
    all = 1'b0;
    while (!all && k <= 400) begin
      if (r.mid_start) start = (k == 4);
      if (k == 1) begin
        chk($sformatf("r%0d_clr_done", id), done[0], 0);
        chk($sformatf("r%0d_clr_fcnt", id), fcnt[0], 0);
        chk($sformatf("r%0d_clr_fvld", id), fvld[0], 0);
      end
      if (k <= 8)
        chk($sformatf("r%0d_vec%0d", id, k - 1),
            {cin[0], b[0], a[0]},
            {vt[k-1].cin, vt[k-1].b, vt[k-1].a});
      if (k == 9)
        chk($sformatf("r%0d_drain_stim", id),
            {cin[0], b[0], a[0]}, 0);
      all = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (busy[i]) bc[i]++;
        if (done[i] && dk[i] == 0) dk[i] = k;
        if (dk[i] == 0) all = 1'b0;
      end
      if (!all) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ef = (i == 1) ? r.fail_u1 : r.fail_small;
      chk($sformatf("r%0d_done_cyc_u%0d", id, i), dk[i],
          1 + 8 * loops_of(i) + lat_of(i));
      chk($sformatf("r%0d_busy_len_u%0d", id, i), bc[i],
          8 * loops_of(i) + lat_of(i));
      chk($sformatf("r%0d_fcnt_u%0d", id, i), fcnt[i], ef);
      chk($sformatf("r%0d_fvld_u%0d", id, i), fvld[i], r.fvld);
      chk($sformatf("r%0d_fvec_u%0d", id, i), fvec[i], r.first);
      chk($sformatf("r%0d_pass_u%0d", id, i), pass[i], r.pass);
      chk($sformatf("r%0d_busy_end_u%0d", id, i), busy[i], 0);
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b1};
    vt[7] = '{1'b1, 1'b1, 1'b1};

    // fault, mid_start, fail(u0/u2/u3), fail(u1), first, fvld, pass
    rt[0] = '{0, 1'b0, 0,   0, 0, 1'b0, 1'b1};
    rt[1] = '{1, 1'b0, 4, 160, 1, 1'b1, 1'b0};
    rt[2] = '{2, 1'b0, 8, 255, 0, 1'b1, 1'b0};
    rt[3] = '{0, 1'b1, 0,   0, 0, 1'b0, 1'b1};
    rt[4] = '{0, 1'b0, 0,   0, 0, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    fault = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy[0], 0);

    for (int r = 0; r < 4; r++) run(r, rt[r]);

    // abort in the middle of a sweep
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_abort_busy", busy[0], 0);
    chk("post_abort_done", done[0], 0);
    chk("post_abort_stim", {cin[0], b[0], a[0]}, 0);

    run(4, rt[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
